// File: rtl/jk_fsm_bank.sv
// rtl/jk_fsm_bank.sv - bank of dwell-gated OFF/ON JK state machines with aggregate status
module jk_fsm_bank #(
  parameter int CHANNELS = 4,
  parameter int DWELL_W  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            en,
  input  logic [CHANNELS-1:0]             j,
  input  logic [CHANNELS-1:0]             k,
  input  logic [CHANNELS-1:0]             jk_toggle,
  input  logic [DWELL_W-1:0]              min_dwell,
  output logic [CHANNELS-1:0]             state,
  output logic [CHANNELS-1:0]             changed,
  output logic [$clog2(CHANNELS+1)-1:0]   on_count,
  output logic                            any_on,
  output logic                            all_on
);

  localparam int CNT_W = $clog2(CHANNELS+1);
  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_ON  = 1'b1;
  localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};

  logic [CHANNELS-1:0] state_q, state_d;
  logic [CHANNELS-1:0] changed_q, changed_d;
  logic [CNT_W-1:0]    on_count_q, on_count_d;
  logic [DWELL_W-1:0]  dwell_q [CHANNELS];
  logic [DWELL_W-1:0]  dwell_d [CHANNELS];
  logic [CHANNELS-1:0] want;

  always_comb begin
    state_d    = state_q;
    changed_d  = '0;
    want       = state_q;
    on_count_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      dwell_d[i] = dwell_q[i];
      if (en) begin
        unique case ({j[i], k[i]})
          2'b10:   want[i] = ST_ON;
          2'b01:   want[i] = ST_OFF;
          2'b11:   want[i] = jk_toggle[i] ? ~state_q[i] : state_q[i];
          default: want[i] = state_q[i];
        endcase
      end
      // A blocked request is simply dropped; it is re-tried while still asserted.
      if ((want[i] != state_q[i]) && (dwell_q[i] >= min_dwell)) begin
        state_d[i]   = want[i];
        changed_d[i] = 1'b1;
        dwell_d[i]   = '0;
      end else if (dwell_q[i] != DWELL_MAX) begin
        dwell_d[i] = dwell_q[i] + DWELL_W'(1);
      end
      on_count_d = on_count_d + CNT_W'(state_d[i]);
    end
  end

  // Dwell counters reset saturated so the first request after reset is never blocked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= '0;
      changed_q  <= '0;
      on_count_q <= '0;
      for (int i = 0; i < CHANNELS; i++) dwell_q[i] <= DWELL_MAX;
    end else begin
      state_q    <= state_d;
      changed_q  <= changed_d;
      on_count_q <= on_count_d;
      for (int i = 0; i < CHANNELS; i++) dwell_q[i] <= dwell_d[i];
    end
  end

  assign state    = state_q;
  assign changed  = changed_q;
  assign on_count = on_count_q;
  assign any_on   = |state_q;
  assign all_on   = &state_q;

endmodule

// File: tb/tb_jk_fsm_bank.sv
// tb/tb_jk_fsm_bank.sv - directed self-checking bench for jk_fsm_bank
module tb_jk_fsm_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [3:0] j, k, jk_toggle;
  logic [3:0] min_dwell;
  logic [3:0] state, changed;
  logic [2:0] on_count;
  logic       any_on, all_on;

  int checks = 0;
  int errors = 0;

  jk_fsm_bank #(.CHANNELS(4), .DWELL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .j(j), .k(k), .jk_toggle(jk_toggle),
    .min_dwell(min_dwell), .state(state), .changed(changed), .on_count(on_count),
    .any_on(any_on), .all_on(all_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [3:0] ch,
                         input logic [2:0] cnt, input logic ao, input logic al);
    chk({tag, ".state"},    32'(state),    32'(st));
    chk({tag, ".changed"},  32'(changed),  32'(ch));
    chk({tag, ".on_count"}, 32'(on_count), 32'(cnt));
    chk({tag, ".any_on"},   32'(any_on),   32'(ao));
    chk({tag, ".all_on"},   32'(all_on),   32'(al));
  endtask

  initial begin
    reset_n = 1'b1; en = 1'b0; j = '0; k = '0; jk_toggle = '0; min_dwell = '0;
    #1 reset_n = 1'b0;
    #1 chk_all("reset", 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0);
    tick(); tick();
    @(negedge clk) reset_n = 1'b1;

    // channel 0 hold-mode basics
    en = 1'b1; j = 4'b0001;
    tick(); chk_all("t2_set", 4'b0001, 4'b0001, 3'd1, 1'b1, 1'b0);
    k = 4'b0001;
    tick(); chk_all("t2_jk_hold", 4'b0001, 4'b0000, 3'd1, 1'b1, 1'b0);
    j = 4'b0000;
    tick(); chk_all("t2_clr", 4'b0000, 4'b0001, 3'd0, 1'b0, 1'b0);
    k = 4'b0000;
    tick(); chk_all("t2_idle", 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0);

    // channel 1 toggling every edge
    jk_toggle = 4'b0010; j = 4'b0010; k = 4'b0010;
    tick(); chk_all("t3_e1", 4'b0010, 4'b0010, 3'd1, 1'b1, 1'b0);
    tick(); chk_all("t3_e2", 4'b0000, 4'b0010, 3'd0, 1'b0, 1'b0);
    tick(); chk_all("t3_e3", 4'b0010, 4'b0010, 3'd1, 1'b1, 1'b0);
    tick(); chk_all("t3_e4", 4'b0000, 4'b0010, 3'd0, 1'b0, 1'b0);
    j = '0; k = '0; jk_toggle = '0;
    tick(); chk("t3_quiet.changed", 32'(changed), 32'h0);

    // dwell gating, min_dwell=3: short pulse dropped on ch0
    min_dwell = 4'd3; j = 4'b0001;
    tick(); chk_all("t4a_e0", 4'b0001, 4'b0001, 3'd1, 1'b1, 1'b0);
    j = '0; k = 4'b0001;
    tick(); chk_all("t4a_pulse", 4'b0001, 4'b0000, 3'd1, 1'b1, 1'b0);
    k = '0;
    tick(); chk_all("t4a_after", 4'b0001, 4'b0000, 3'd1, 1'b1, 1'b0);

    // held clear request on ch2 taken at the 4th edge after turning on
    j = 4'b0100;
    tick(); chk_all("t4b_e0", 4'b0101, 4'b0100, 3'd2, 1'b1, 1'b0);
    j = '0; k = 4'b0100;
    tick(); chk_all("t4b_e1", 4'b0101, 4'b0000, 3'd2, 1'b1, 1'b0);
    tick(); chk_all("t4b_e2", 4'b0101, 4'b0000, 3'd2, 1'b1, 1'b0);
    tick(); chk_all("t4b_e3", 4'b0101, 4'b0000, 3'd2, 1'b1, 1'b0);
    tick(); chk_all("t4b_e4", 4'b0001, 4'b0100, 3'd1, 1'b1, 1'b0);
    k = '0;
    tick(); chk("t4b_quiet.changed", 32'(changed), 32'h0);

    // global enable masks requests
    min_dwell = 4'd0; en = 1'b0; j = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick(); chk_all("t5_dis", 4'b0001, 4'b0000, 3'd1, 1'b1, 1'b0);
    end
    en = 1'b1;
    tick(); chk_all("t5_en", 4'b1111, 4'b1110, 3'd4, 1'b1, 1'b1);
    j = '0;

    // reset dropped between edges with live state
    #2 reset_n = 1'b0;
    #1 chk_all("t1_midreset", 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0);

    // maximal dwell: first request accepted, reversal blocked for 15 edges
    min_dwell = 4'd15;
    @(negedge clk) reset_n = 1'b1;
    j = 4'b0001;
    tick(); chk_all("t6_first", 4'b0001, 4'b0001, 3'd1, 1'b1, 1'b0);
    j = '0; k = 4'b0001;
    for (int n = 0; n < 15; n++) begin
      tick(); chk_all("t6_blocked", 4'b0001, 4'b0000, 3'd1, 1'b1, 1'b0);
    end
    tick(); chk_all("t6_taken", 4'b0000, 4'b0001, 3'd0, 1'b0, 1'b0);
    k = '0;
    for (int n = 0; n < 20; n++) tick();
    chk("t6_idle.changed", 32'(changed), 32'h0);
    j = 4'b0001;
    tick(); chk_all("t6_after_idle", 4'b0001, 4'b0001, 3'd1, 1'b1, 1'b0);
    j = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
